// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory boot loader:
//   - state_t      : loader FSM state encoding
//   - HDR_W        : width of the word-count header (bits)
//   - BYTES_PER_WORD: bytes packed into one instruction word
//   - shift_in_byte: packs the next MSB-first byte into a word accumulator
// ---------------------------------------------------------------------------
package imem_loader_pkg;

    localparam int HDR_W          = 16;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        S_HDR0 = 3'd0,
        S_HDR1 = 3'd1,
        S_DATA = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    // Words arrive MSB first, so every new byte enters at the bottom.
    function automatic logic [31:0] shift_in_byte(input logic [31:0] acc,
                                                  input logic [7:0]  b);
        return {acc[23:0], b};
    endfunction

endpackage

// File: rtl/m_idle_timer.sv
// ---------------------------------------------------------------------------
// m_idle_timer
// Idle-cycle counter for the loader. Counts enabled cycles since the last
// clear and raises a one-cycle registered pulse when the count reaches
// TIMEOUT-1; the consumer acts on the pulse at the following edge, so the
// consumer reacts TIMEOUT cycles after the clear. The count then holds.
// Ports:
//   clk     in  clock
//   rst     in  synchronous active-high reset
//   clr     in  restart the count (an accepted byte)
//   en      in  count this cycle
//   expired out one-cycle pulse, registered
// ---------------------------------------------------------------------------
module m_idle_timer #(
    parameter int TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(TIMEOUT - 2);

    logic [CW-1:0] cnt;

    // Saturating idle counter with a registered expiry pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= {CW{1'b0}};
            expired <= 1'b0;
        end else if (clr) begin
            cnt     <= {CW{1'b0}};
            expired <= 1'b0;
        end else if (en && (cnt != CNT_LAST)) begin
            cnt     <= cnt + 1'b1;
            expired <= (cnt == CNT_PRE);
        end else begin
            expired <= 1'b0;
        end
    end

endmodule

// File: rtl/m_imem_loader.sv
// ---------------------------------------------------------------------------
// m_imem_loader
// Boot-time loader: receives a byte stream (2-byte MSB-first word count N,
// then 4*N MSB-first word bytes), writes the words to instruction memory at
// word addresses 0..N-1, and holds the processor in reset until the last
// write has been issued.
// Ports:
//   w_clk       in   clock (rising edge)
//   w_rst       in   synchronous active-high reset
//   w_din       in   [7:0] incoming byte
//   w_dvalid    in   w_din valid
//   r_dready    out  byte accepted when w_dvalid & r_dready
//   r_we        out  one-cycle memory write strobe
//   r_waddr     out  [ADDR_W-1:0] word write address
//   r_wdata     out  [31:0] word write data
//   r_proc_rst  out  processor reset, low only once the load is complete
//   r_done      out  load complete (sticky)
//   r_err       out  load aborted (sticky)
//   r_nwords    out  [ADDR_W:0] words written so far
// ---------------------------------------------------------------------------
module m_imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int DEPTH   = 4096,
    parameter int TIMEOUT = 1000000
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic [7:0]        w_din,
    input  logic              w_dvalid,
    output logic              r_dready,
    output logic              r_we,
    output logic [ADDR_W-1:0] r_waddr,
    output logic [31:0]       r_wdata,
    output logic              r_proc_rst,
    output logic              r_done,
    output logic              r_err,
    output logic [ADDR_W:0]   r_nwords
);

    localparam int             LIM_W     = HDR_W + 1;
    localparam logic [LIM_W-1:0] DEPTH_LIM = LIM_W'(DEPTH);

    state_t            state;
    logic [HDR_W-1:0]  hdr_n;
    logic              hdr_chk;     // header complete, N evaluated this cycle
    logic [31:0]       pack;
    logic [1:0]        bcnt;

    logic              accept;
    logic              timer_en;
    logic              expired;
    logic [ADDR_W:0]   nwords_next;
    logic              last_word;
    logic              n_bad;

    // Handshake qualification and header/word-count decode.
    always_comb begin
        accept      = w_dvalid & r_dready;
        timer_en    = (state == S_HDR1) || (state == S_DATA);
        nwords_next = r_nwords + 1'b1;
        last_word   = (32'(nwords_next) == 32'(hdr_n));
        n_bad       = (hdr_n == {HDR_W{1'b0}}) || ({1'b0, hdr_n} > DEPTH_LIM);
    end

    m_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk     (w_clk),
        .rst     (w_rst),
        .clr     (accept),
        .en      (timer_en),
        .expired (expired)
    );

    // Loader FSM with all outputs registered.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state      <= S_HDR0;
            hdr_n      <= {HDR_W{1'b0}};
            hdr_chk    <= 1'b0;
            pack       <= 32'd0;
            bcnt       <= 2'd0;
            r_dready   <= 1'b1;
            r_we       <= 1'b0;
            r_waddr    <= {ADDR_W{1'b0}};
            r_wdata    <= 32'd0;
            r_proc_rst <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_nwords   <= {(ADDR_W + 1){1'b0}};
        end else begin
            r_we <= 1'b0;
            case (state)
                S_HDR0: begin
                    if (accept) begin
                        hdr_n[15:8] <= w_din;
                        state       <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    // Low byte lands first; N is judged on the next cycle
                    // with the handshake closed.
                    if (hdr_chk) begin
                        hdr_chk <= 1'b0;
                        if (n_bad) begin
                            state    <= S_ERR;
                            r_err    <= 1'b1;
                            r_dready <= 1'b0;
                        end else begin
                            state    <= S_DATA;
                            r_dready <= 1'b1;
                        end
                    end else if (accept) begin
                        hdr_n[7:0] <= w_din;
                        hdr_chk    <= 1'b1;
                        r_dready   <= 1'b0;
                    end else if (expired) begin
                        state    <= S_ERR;
                        r_err    <= 1'b1;
                        r_dready <= 1'b0;
                    end
                end
                S_DATA: begin
                    // A byte arriving on the expiry edge still counts.
                    if (accept) begin
                        pack <= shift_in_byte(pack, w_din);
                        bcnt <= bcnt + 2'd1;
                        if (bcnt == 2'd3) begin
                            r_we     <= 1'b1;
                            r_waddr  <= r_nwords[ADDR_W-1:0];
                            r_wdata  <= shift_in_byte(pack, w_din);
                            r_nwords <= nwords_next;
                            if (last_word) begin
                                state    <= S_DONE;
                                r_dready <= 1'b0;
                            end
                        end
                    end else if (expired) begin
                        state    <= S_ERR;
                        r_err    <= 1'b1;
                        r_dready <= 1'b0;
                    end
                end
                S_DONE: begin
                    // Release lags the final strobe by one cycle so the
                    // write commits before the first fetch.
                    r_done     <= 1'b1;
                    r_proc_rst <= 1'b0;
                    r_dready   <= 1'b0;
                end
                S_ERR: begin
                    r_dready <= 1'b0;
                end
                default: begin
                    state    <= S_ERR;
                    r_err    <= 1'b1;
                    r_dready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_m_imem_loader
// Self-checking bench: a byte-count based reference model predicts every
// output each cycle; directed frames pin the model with literal values.
// ---------------------------------------------------------------------------
module tb_m_imem_loader;

    localparam int ADDR_W  = 12;
    localparam int DEPTH   = 4096;
    localparam int TIMEOUT = 16;

    logic              w_clk = 1'b0;
    logic              w_rst;
    logic [7:0]        w_din;
    logic              w_dvalid;
    logic              r_dready;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [31:0]       r_wdata;
    logic              r_proc_rst;
    logic              r_done;
    logic              r_err;
    logic [ADDR_W:0]   r_nwords;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    m_imem_loader #(
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .w_clk      (w_clk),
        .w_rst      (w_rst),
        .w_din      (w_din),
        .w_dvalid   (w_dvalid),
        .r_dready   (r_dready),
        .r_we       (r_we),
        .r_waddr    (r_waddr),
        .r_wdata    (r_wdata),
        .r_proc_rst (r_proc_rst),
        .r_done     (r_done),
        .r_err      (r_err),
        .r_nwords   (r_nwords)
    );

    always #5 w_clk = ~w_clk;

    always @(posedge w_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks bytes accepted since reset; the frame position alone decides
    // what each byte means.
    bit          mdl_on = 1'b0;
    int          m_bytes, m_n, m_idle, m_nw, m_waddr, m_base;
    logic        m_acc, m_dready, m_we, m_done, m_err, m_prst, m_chk, m_fin;
    logic [31:0] m_wdata;
    logic [7:0]  m_q[$];

    always @(posedge w_clk) begin
        m_acc = w_dvalid && m_dready;
        m_we  = 1'b0;
        if (w_rst) begin
            mdl_on  = 1'b1;
            m_bytes = 0; m_n = 0; m_idle = 0; m_nw = 0; m_waddr = 0;
            m_q.delete();
            m_dready = 1'b1; m_done = 1'b0; m_err = 1'b0; m_prst = 1'b1;
            m_chk = 1'b0; m_fin = 1'b0; m_wdata = 32'd0;
        end else if (mdl_on) begin
            if (m_err || m_done) begin
                m_dready = 1'b0;
            end else if (m_fin) begin
                m_done = 1'b1; m_prst = 1'b0; m_dready = 1'b0;
            end else if (m_chk) begin
                m_chk = 1'b0;
                m_idle++;
                if (m_n == 0 || m_n > DEPTH) begin
                    m_err = 1'b1; m_dready = 1'b0;
                end else begin
                    m_dready = 1'b1;
                end
            end else if (m_acc) begin
                m_idle = 0;
                m_bytes++;
                if (m_bytes == 1) begin
                    m_n = int'(w_din) * 256;
                end else if (m_bytes == 2) begin
                    m_n = m_n + int'(w_din);
                    m_chk = 1'b1; m_dready = 1'b0;
                end else begin
                    m_q.push_back(w_din);
                    if (m_q.size() % 4 == 0) begin
                        m_base  = m_q.size() - 4;
                        m_wdata = {m_q[m_base], m_q[m_base+1], m_q[m_base+2], m_q[m_base+3]};
                        m_waddr = m_nw;
                        m_nw++;
                        m_we = 1'b1;
                        if (m_nw == m_n) begin
                            m_fin = 1'b1; m_dready = 1'b0;
                        end
                    end
                end
            end else if (m_bytes >= 1) begin
                m_idle++;
                if (m_idle >= TIMEOUT) begin
                    m_err = 1'b1; m_dready = 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge w_clk) begin
        if (mdl_on) begin
            check("dready", 32'(r_dready), 32'(m_dready));
            check("we", 32'(r_we), 32'(m_we));
            if (m_we) begin
                check("waddr", 32'(r_waddr), 32'(m_waddr));
                check("wdata", r_wdata, m_wdata);
            end
            check("done", 32'(r_done), 32'(m_done));
            check("err", 32'(r_err), 32'(m_err));
            check("proc_rst", 32'(r_proc_rst), 32'(m_prst));
            check("nwords", 32'(r_nwords), 32'(m_nw));
        end
    end

    // ---------------- observed write log ----------------
    int          log_addr[$];
    logic [31:0] log_data[$];
    int          log_cyc[$];
    int          done_cyc = -1;

    always @(negedge w_clk) begin
        if (r_we === 1'b1) begin
            log_addr.push_back(int'(r_waddr));
            log_data.push_back(r_wdata);
            log_cyc.push_back(cyc);
        end
        if (r_done === 1'b1 && done_cyc < 0) done_cyc = cyc;
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        w_rst = 1'b1; w_dvalid = 1'b0; w_din = 8'd0;
        repeat (2) @(negedge w_clk);
        w_rst = 1'b0;
        log_addr.delete(); log_data.delete(); log_cyc.delete();
        done_cyc = -1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd_gap);
        int guard = 0;
        if (rnd_gap) begin
            while ($urandom_range(0, 1) == 1 && guard < 8) begin
                w_dvalid = 1'b0; w_din = 8'($urandom);
                @(negedge w_clk);
                guard++;
            end
        end
        w_din = b; w_dvalid = 1'b1; guard = 0;
        while (r_dready !== 1'b1 && guard < 50) begin
            @(negedge w_clk);
            guard++;
        end
        if (guard >= 50) begin
            checks++; failures++;
            $display("FAIL send_byte timeout actual=no_ready expected=ready byte=0x%0h", b);
            w_dvalid = 1'b0;
        end else begin
            @(negedge w_clk);
            w_dvalid = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] fr[$], input bit rnd_gap);
        foreach (fr[i]) send_byte(fr[i], rnd_gap);
    endtask

    logic [7:0] frame[$];
    logic [7:0] rb[$];
    int         k;

    initial begin
        w_rst = 1'b1; w_dvalid = 1'b0; w_din = 8'd0;
        do_reset();

        // Reset values
        check("rst_dready", 32'(r_dready), 32'd1);
        check("rst_proc_rst", 32'(r_proc_rst), 32'd1);
        check("rst_we", 32'(r_we), 32'd0);
        check("rst_waddr", 32'(r_waddr), 32'd0);
        check("rst_wdata", r_wdata, 32'd0);
        check("rst_flags", {30'd0, r_done, r_err}, 32'd0);
        check("rst_nwords", 32'(r_nwords), 32'd0);

        // Two-word load, back to back
        frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h44, 8'h00, 8'h00, 8'h00};
        send_frame(frame, 1'b0);
        // Extra bytes after completion must be refused
        w_din = 8'hA5; w_dvalid = 1'b1;
        repeat (4) @(negedge w_clk);
        w_dvalid = 1'b0;
        check("t1_nwrites", 32'(log_addr.size()), 32'd2);
        if (log_addr.size() == 2) begin
            check("t1_addr0", 32'(log_addr[0]), 32'd0);
            check("t1_data0", log_data[0], 32'h20080005);
            check("t1_addr1", 32'(log_addr[1]), 32'd1);
            check("t1_data1", log_data[1], 32'h44000000);
            check("t1_done_lag", 32'(done_cyc - log_cyc[1]), 32'd1);
        end
        check("t1_nwords", 32'(r_nwords), 32'd2);
        check("t1_done", 32'(r_done), 32'd1);
        check("t1_proc_rst", 32'(r_proc_rst), 32'd0);

        // N == 0
        do_reset();
        frame = '{8'h00, 8'h00};
        send_frame(frame, 1'b0);
        check("t2_err_early", 32'(r_err), 32'd0);
        @(negedge w_clk);
        check("t2_err", 32'(r_err), 32'd1);
        repeat (3) @(negedge w_clk);
        check("t2_proc_rst", 32'(r_proc_rst), 32'd1);
        check("t2_nwrites", 32'(log_addr.size()), 32'd0);

        // N > DEPTH
        do_reset();
        frame = '{8'h10, 8'h01};
        send_frame(frame, 1'b0);
        repeat (3) @(negedge w_clk);
        check("t3_err", 32'(r_err), 32'd1);
        check("t3_nwrites", 32'(log_addr.size()), 32'd0);

        // Timeout after two data bytes
        do_reset();
        frame = '{8'h00, 8'h01, 8'hAA, 8'hBB};
        send_frame(frame, 1'b0);
        k = 0;
        while (r_err !== 1'b1 && k < 40) begin
            @(negedge w_clk);
            k++;
        end
        check("t4_timeout_cycles", 32'(k), 32'd16);
        check("t4_nwrites", 32'(log_addr.size()), 32'd0);
        check("t4_proc_rst", 32'(r_proc_rst), 32'd1);

        // Three-word load with random valid gaps, then the same back to back
        rb.delete();
        for (int i = 0; i < 12; i++) rb.push_back(8'($urandom));
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            frame = '{8'h00, 8'h03};
            foreach (rb[i]) frame.push_back(rb[i]);
            send_frame(frame, (pass == 0));
            repeat (3) @(negedge w_clk);
            check("t5_nwrites", 32'(log_addr.size()), 32'd3);
            for (int w = 0; w < 3 && w < log_addr.size(); w++) begin
                check("t5_addr", 32'(log_addr[w]), 32'(w));
                check("t5_data", log_data[w], {rb[4*w], rb[4*w+1], rb[4*w+2], rb[4*w+3]});
            end
            check("t5_done", 32'(r_done), 32'd1);
        end

        // Reset mid-load, then a fresh one-word frame
        do_reset();
        frame = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_frame(frame, 1'b0);
        do_reset();
        frame = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_frame(frame, 1'b0);
        repeat (3) @(negedge w_clk);
        check("t6_nwrites", 32'(log_addr.size()), 32'd1);
        if (log_addr.size() == 1) begin
            check("t6_addr", 32'(log_addr[0]), 32'd0);
            check("t6_data", log_data[0], 32'hDEADBEEF);
        end
        check("t6_nwords", 32'(r_nwords), 32'd1);
        check("t6_proc_rst", 32'(r_proc_rst), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
